// File: rtl/ddfs_cfg_pkg.sv
// Shared types, sequencer states and expected LM/en encoding for the DDFS
// lane-split configuration path.
package ddfs_cfg_pkg;

    typedef logic [1:0] ddfs_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_DONE
    } seq_state_t;

    // Modes 00/01 are LM (single-lane) modes; 10/11 split across lanes.
    function automatic logic exp_lm(input ddfs_mode_t m);
        return ~m[1];
    endfunction

    function automatic logic [2:0] exp_en(input ddfs_mode_t m);
        logic [2:0] en;
        case (m)
            2'b00:   en = 3'b000;
            2'b01:   en = 3'b001;
            2'b10:   en = 3'b011;
            default: en = 3'b111;
        endcase
        return en;
    endfunction

    // One mode step toward the target, so lanes are enabled/disabled singly.
    function automatic ddfs_mode_t mode_step(input ddfs_mode_t cur, input ddfs_mode_t tgt);
        ddfs_mode_t nxt;
        if (tgt > cur) begin
            nxt = cur + 2'd1;
        end else if (tgt < cur) begin
            nxt = cur - 2'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ddfs_mode_sequencer_if.sv
// Host-side request handshake and status of the DDFS mode sequencer.
interface ddfs_mode_sequencer_if;

    logic                     req_valid;
    ddfs_cfg_pkg::ddfs_mode_t req_mode;
    logic                     req_ready;
    logic                     busy;
    logic                     cfg_done;
    logic                     cfg_err;

    modport master (
        output req_valid, req_mode,
        input  req_ready, busy, cfg_done, cfg_err
    );

    modport slave (
        input  req_valid, req_mode,
        output req_ready, busy, cfg_done, cfg_err
    );

endinterface

// File: rtl/ddfs_cfg_checker.sv
// Registered compare of the configuration block's LM/en against the expected
// encoding of the applied mode; the error flag is sticky until clr.
module ddfs_cfg_checker
    import ddfs_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       check,
    input  ddfs_mode_t mode,
    input  logic       conf_lm,
    input  logic [2:0] conf_en,
    output logic       err
);

    logic err_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (clr) begin
            err_reg <= 1'b0;
        end else if (check && ((conf_lm != exp_lm(mode)) || (conf_en != exp_en(mode)))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: rtl/ddfs_mode_sequencer.sv
// Hitless DDFS mode-change sequencer: freeze, drain, apply, settle, check, release.
// Optional MODE_STEP_EN: walk the mode one step per APPLY instead of jumping.
module ddfs_mode_sequencer
    import ddfs_cfg_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    ddfs_mode_sequencer_if.slave        host,
    output ddfs_mode_t                  mode,
    input  logic                        conf_lm,
    input  logic [2:0]                  conf_en,
    output logic                        dp_hold
);

    localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    seq_state_t     state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    ddfs_mode_t     target_reg, target_next;
    ddfs_mode_t     mode_reg, mode_next;
    logic           accept;
    logic           settle_check;

    assign accept = host.req_valid && (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            target_reg <= 2'b00;
            mode_reg   <= 2'b00;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            mode_reg   <= mode_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        target_next  = target_reg;
        mode_next    = mode_reg;
        settle_check = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    target_next = host.req_mode;
                    if (host.req_mode == mode_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRAIN;
                        cnt_next   = CW'(DRAIN_CYCLES);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_APPLY;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_APPLY: begin
`ifdef MODE_STEP_EN
                mode_next  = mode_step(mode_reg, target_reg);
`else
                mode_next  = target_reg;
`endif
                cnt_next   = CW'(SETTLE_CYCLES);
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Last settle cycle: outputs of the config block are valid now.
                if (cnt_reg == CW'(1)) begin
                    settle_check = 1'b1;
                    state_next   = (mode_reg != target_reg) ? ST_APPLY : ST_DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    ddfs_cfg_checker u_checker (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .check   (settle_check),
        .mode    (mode_reg),
        .conf_lm (conf_lm),
        .conf_en (conf_en),
        .err     (host.cfg_err)
    );

    assign mode          = mode_reg;
    assign dp_hold       = (state_reg == ST_DRAIN) || (state_reg == ST_APPLY) || (state_reg == ST_SETTLE);
    assign host.req_ready = (state_reg == ST_IDLE);
    assign host.busy      = (state_reg != ST_IDLE);
    assign host.cfg_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ddfs_mode_sequencer.sv
// Bench for ddfs_mode_sequencer: cycle-index model of each request plus a
// registered configuration-block model with optional en fault on mode 11.
`timescale 1ns/1ps
module tb_ddfs_mode_sequencer;

    localparam int D = 4;
    localparam int S = 3;

`ifdef MODE_STEP_EN
    localparam int B_M6 = 1;
    localparam int B_T  = 13;
    localparam int E_M6 = 1;
    localparam int E_T  = 17;
`else
    localparam int B_M6 = 2;
    localparam int B_T  = 9;
    localparam int E_M6 = 3;
    localparam int E_T  = 9;
`endif

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       conf_lm;
    logic [2:0] conf_en;
    logic       dp_hold;
    bit         fault;
    logic [3:0] lm_tab;

    int pass_cnt;
    int chk_cnt;

    ddfs_mode_sequencer_if host_if();

    ddfs_mode_sequencer #(
        .DRAIN_CYCLES  (D),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .host    (host_if),
        .mode    (mode),
        .conf_lm (conf_lm),
        .conf_en (conf_en),
        .dp_hold (dp_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] en_of(input logic [1:0] m);
        logic [2:0] e;
        case (m)
            2'd0:    e = 3'b000;
            2'd1:    e = 3'b001;
            2'd2:    e = 3'b011;
            default: e = 3'b111;
        endcase
        return e;
    endfunction

    // Configuration block: one registered stage, reset along with the sequencer.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conf_lm <= 1'b1;
            conf_en <= 3'b000;
        end else begin
            conf_lm <= lm_tab[mode];
            conf_en <= (fault && mode == 2'd3) ? 3'b000 : en_of(mode);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_n is the cycle index since the accepting edge (0 = idle).
    int m_n, m_t, m_k, m_cur, m_tgt;
    int m_app[3];
    bit m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n = 0; m_t = 0; m_k = 0; m_cur = 0; m_tgt = 0; m_err = 0;
        end else if (m_n == 0) begin
            if (host_if.req_valid) begin
                m_tgt = int'(host_if.req_mode);
                m_err = 0;
                m_k   = 0;
                if (m_tgt != m_cur) begin
`ifdef MODE_STEP_EN
                    m_k = (m_tgt > m_cur) ? m_tgt - m_cur : m_cur - m_tgt;
                    for (int j = 0; j < m_k; j++)
                        m_app[j] = (m_tgt > m_cur) ? m_cur + j + 1 : m_cur - j - 1;
`else
                    m_k = 1;
                    m_app[0] = m_tgt;
`endif
                end
                m_t = (m_k == 0) ? 1 : D + m_k * (1 + S) + 1;
                m_n = 1;
            end
        end else begin
            m_n++;
            for (int j = 0; j < m_k; j++)
                if (fault && m_app[j] == 3 && m_n == D + (j + 1) * (1 + S) + 1)
                    m_err = 1;
            if (m_n > m_t) begin
                m_n   = 0;
                m_cur = m_tgt;
            end
        end
    end

    task automatic compare_cycle();
        int applied = 0;
        int em;
        for (int j = 0; j < m_k; j++)
            if (m_n != 0 && m_n >= D + 2 + j * (1 + S)) applied++;
        em = (applied == 0) ? m_cur : m_app[applied - 1];
        chk("cyc_mode",  int'(mode), em);
        chk("cyc_ready", int'(host_if.req_ready), int'(m_n == 0));
        chk("cyc_busy",  int'(host_if.busy), int'(m_n != 0));
        chk("cyc_done",  int'(host_if.cfg_done), int'(m_n != 0 && m_n == m_t));
        chk("cyc_hold",  int'(dp_hold), int'(m_n != 0 && m_k != 0 && m_n < m_t));
        chk("cyc_err",   int'(host_if.cfg_err), int'(m_err));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    task automatic wait_cyc(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Leaves the caller at the negedge of cycle 1 after the accepting edge.
    task automatic send(input logic [1:0] m);
        @(negedge clk);
        host_if.req_valid = 1'b1;
        host_if.req_mode  = m;
        $display("txn: request mode %0d from %0d at %0t", m, m_cur, $time);
        @(negedge clk);
        host_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_n != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (m_n != 0) chk("idle_timeout", m_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        lm_tab   = 4'b0011;
        fault    = 1'b0;
        reset_n  = 1'b0;
        host_if.req_valid = 1'b0;
        host_if.req_mode  = 2'b00;
        wait_cyc(2);
        chk("rst_mode",  int'(mode), 0);
        chk("rst_ready", int'(host_if.req_ready), 1);
        chk("rst_busy",  int'(host_if.busy), 0);
        chk("rst_hold",  int'(dp_hold), 0);
        reset_n = 1'b1;
        wait_cyc(1);

        // 00 -> 10
        send(2'd2);
        chk("b_hold_c1",  int'(dp_hold), 1);
        chk("b_ready_c1", int'(host_if.req_ready), 0);
        wait_cyc(4);
        chk("b_mode_c5", int'(mode), 0);
        wait_cyc(1);
        chk("b_mode_c6", int'(mode), B_M6);
        wait_cyc(B_T - 7);
        chk("b_hold_last", int'(dp_hold), 1);
        chk("b_done_early", int'(host_if.cfg_done), 0);
        wait_cyc(1);
        chk("b_done", int'(host_if.cfg_done), 1);
        chk("b_hold_done", int'(dp_hold), 0);
        wait_cyc(1);
        chk("b_ready_after", int'(host_if.req_ready), 1);
        chk("b_err", int'(host_if.cfg_err), 0);
        wait_idle();

        // 10 -> 01, then same-mode 01 -> 01
        send(2'd1);
        wait_idle();
        send(2'd1);
        chk("same_done_c1", int'(host_if.cfg_done), 1);
        chk("same_hold_c1", int'(dp_hold), 0);
        chk("same_mode_c1", int'(mode), 1);
        wait_cyc(1);
        chk("same_ready_c2", int'(host_if.req_ready), 1);
        wait_idle();

        // 01 -> 11 with a stray request for 01 while busy
        send(2'd3);
        wait_cyc(2);
        host_if.req_valid = 1'b1;
        host_if.req_mode  = 2'd1;
        chk("busy_ready_c3", int'(host_if.req_ready), 0);
        wait_cyc(1);
        host_if.req_valid = 1'b0;
        wait_idle();
        wait_cyc(3);
        chk("busy_ignored_mode", int'(mode), 3);
        chk("busy_ignored_busy", int'(host_if.busy), 0);

        // 00 -> 11 with the configuration block returning en=000 for mode 11
        send(2'd0);
        wait_idle();
        fault = 1'b1;
        send(2'd3);
        wait_cyc(5);
        chk("e_mode_c6", int'(mode), E_M6);
`ifdef MODE_STEP_EN
        wait_cyc(4);
        chk("e_mode_c10", int'(mode), 2);
        wait_cyc(4);
        chk("e_mode_c14", int'(mode), 3);
        wait_cyc(2);
`else
        wait_cyc(2);
`endif
        chk("e_err_before", int'(host_if.cfg_err), 0);
        chk("e_mode_final", int'(mode), 3);
        wait_cyc(1);
        chk("e_done", int'(host_if.cfg_done), 1);
        chk("e_err_set", int'(host_if.cfg_err), 1);
        wait_idle();
        wait_cyc(3);
        chk("e_err_sticky", int'(host_if.cfg_err), 1);
        fault = 1'b0;
        send(2'd2);
        chk("e_err_cleared", int'(host_if.cfg_err), 0);
        wait_idle();

        // 10 -> 11, reset asserted during SETTLE
        send(2'd3);
        wait_cyc(6);
        chk("f_mode_c7", int'(mode), 3);
        chk("f_hold_c7", int'(dp_hold), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("f_rst_mode",  int'(mode), 0);
        chk("f_rst_hold",  int'(dp_hold), 0);
        chk("f_rst_busy",  int'(host_if.busy), 0);
        chk("f_rst_ready", int'(host_if.req_ready), 1);
        chk("f_rst_err",   int'(host_if.cfg_err), 0);
        wait_cyc(2);
        reset_n = 1'b1;
        send(2'd1);
        wait_idle();
        chk("f_after_mode", int'(mode), 1);
        chk("f_after_err",  int'(host_if.cfg_err), 0);
        wait_cyc(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
